// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared mode/state encodings and reset divisor for the tick generator
package tick_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 10 ms at 100 MHz
  localparam int unsigned DEF_DIV_10MS = 999_999;

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one tick channel: divisor counter with periodic/one-shot FSM
module tick_chan
  import tick_pkg::*;
#(
  parameter int          CNT_W   = 20,
  parameter int unsigned DEF_DIV = DEF_DIV_10MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick,
  output logic             busy
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   div, div_n;
  logic               mode, mode_n;
  logic               en_q;
  logic               rise;

  assign rise = en & ~en_q;
  assign busy = (state == ST_RUN);
  assign tick = (state == ST_RUN) && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      div   <= CNT_W'(DEF_DIV);
      mode  <= MODE_PERIODIC;
      en_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      div   <= div_n;
      mode  <= mode_n;
      en_q  <= en;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    mode_n  = mode;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (wr) begin
          div_n  = wr_div;
          mode_n = wr_mode;
        end
        // the start condition follows the mode being written this cycle, if any
        if ((mode_n == MODE_PERIODIC) ? en : rise) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = '0;
          if (mode == MODE_ONESHOT) state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        // the top only grants a write here on a tick cycle, i.e. a period boundary
        if (wr) begin
          div_n  = wr_div;
          mode_n = wr_mode;
          cnt_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - multi-channel tick generator with valid/ready per-channel config
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter  int          NCH     = 4,
  parameter  int          CNT_W   = 20,
  parameter  int unsigned DEF_DIV = DEF_DIV_10MS,
  localparam int          CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  logic [(1<<CH_W)-1:0] ready_vec;
  logic [NCH-1:0]       wr;

  // unpopulated channel codes stay ready so a stray write is simply dropped
  always_comb begin
    ready_vec = '1;
    for (int i = 0; i < NCH; i++) ready_vec[i] = ~busy[i] | tick[i];
  end

  assign cfg_ready = ready_vec[cfg_ch];

  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .wr_mode (cfg_mode),
      .tick    (tick[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - directed vector bench for tick_gen_multi
module tb_tick_gen_multi;
  import tick_pkg::*;

  localparam int NCH    = 4;
  localparam int CNT_W  = 20;
  localparam int TB_DIV = 99;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;

  logic             s_rst;
  logic [NCH-1:0]   s_en;
  logic             s_v;
  logic [1:0]       s_ch;
  logic [CNT_W-1:0] s_div;
  logic             s_mode;

  int n_tests = 0;
  int n_fail  = 0;
  int tq[$];

  typedef struct {
    logic [3:0]  en;
    logic        v;
    logic [1:0]  ch;
    logic [19:0] div;
    logic        mode;
    logic [3:0]  tick;
    logic [3:0]  busy;
    logic        ready;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  tick_gen_multi #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DEF_DIV (TB_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .tick      (tick),
    .busy      (busy)
  );

  task automatic cyc();
    @(negedge clk);
    rst_n     = s_rst;
    en        = s_en;
    cfg_valid = s_v;
    cfg_ch    = s_ch;
    cfg_div   = s_div;
    cfg_mode  = s_mode;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic collect(input int ch, input int n);
    tq.delete();
    for (int c = 1; c <= n; c++) begin
      cyc();
      if (tick[ch]) tq.push_back(c);
    end
  endtask

  task automatic chk_ticks(input string name, input int ne, input int e0, input int e1,
                           input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({name, "_count"}, tq.size(), ne);
    for (int i = 0; i < ne && i < 4; i++)
      chk($sformatf("%s_at%0d", name, i), (i < tq.size()) ? tq[i] : -1, e[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_c, low_cnt, first, nt;
    bit acc;

    rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    s_rst = 1'b0; s_en = '0; s_v = 1'b0; s_ch = '0; s_div = '0; s_mode = MODE_PERIODIC;

    // ch1 div=3 periodic, then en[1] with a drop/re-enable mid-count
    tbl[0]  = '{4'b0000, 1'b1, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[3]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[4]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0010, 4'b0010, 1'b1};
    tbl[6]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[7]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[9]  = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[12] = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0010, 4'b0010, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 2'd1, 20'd3, 1'b0, 4'b0000, 4'b0000, 1'b1};

    // reset state, then release with en[0] held at the default divisor
    cyc(); cyc();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    s_rst = 1'b1; s_en = 4'b0001;
    cyc();
    chk("rel_busy", busy, 0);
    cyc();
    chk("t1_busy", busy[0], 1);
    tq.delete();
    if (tick[0]) tq.push_back(1);
    for (int c = 2; c <= 210; c++) begin
      cyc();
      if (tick[0]) tq.push_back(c);
    end
    chk_ticks("t1_default", 2, TB_DIV + 1, 2 * (TB_DIV + 1), 0, 0);
    s_en = '0;
    cyc(); cyc();

    for (int i = 0; i < 16; i++) begin
      s_en = tbl[i].en; s_v = tbl[i].v; s_ch = tbl[i].ch; s_div = tbl[i].div; s_mode = tbl[i].mode;
      cyc();
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tick);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].ready);
    end
    s_v = 1'b0; s_en = '0;

    // ch2 one-shot div=5: single tick at cycle 6, then an aborted second run
    s_v = 1'b1; s_ch = 2'd2; s_div = 20'd5; s_mode = MODE_ONESHOT;
    cyc();
    s_v = 1'b0; s_en = 4'b0100;
    cyc();
    first = -1; nt = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 1) chk("t3_busy_start", busy[2], 1);
      if (c == 7) chk("t3_busy_after", busy[2], 0);
      if (tick[2]) begin
        nt++;
        if (first < 0) first = c;
      end
    end
    chk("t3_tick_count", nt, 1);
    chk("t3_tick_cycle", first, 6);
    s_en = 4'b0000; cyc();
    s_en = 4'b0100; cyc();
    nt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) s_en = 4'b0000;
      cyc();
      if (c == 3) chk("t3_abort_busy_pre", busy[2], 1);
      if (tick[2]) nt++;
    end
    chk("t3_abort_ticks", nt, 0);
    chk("t3_abort_busy", busy[2], 0);

    // ch1 div=9 running; reprogram to div=2 at cnt=4, stalls to the tick
    s_v = 1'b1; s_ch = 2'd1; s_div = 20'd9; s_mode = MODE_PERIODIC;
    cyc();
    s_v = 1'b0; s_en = 4'b0010;
    cyc();
    acc = 1'b0; acc_c = -1; low_cnt = 0;
    tq.delete();
    for (int c = 1; c <= 20; c++) begin
      s_v = (c >= 5) && !acc; s_ch = 2'd1; s_div = 20'd2; s_mode = MODE_PERIODIC;
      cyc();
      if (cfg_valid && !cfg_ready) low_cnt++;
      if (cfg_valid && cfg_ready) begin
        acc = 1'b1; acc_c = c;
      end
      if (tick[1]) tq.push_back(c);
    end
    chk("t4_accept_cycle", acc_c, 10);
    chk("t4_stall_cycles", low_cnt, 5);
    chk_ticks("t4_ticks", 4, 10, 13, 16, 19);
    s_v = 1'b0; s_en = '0;
    cyc(); cyc();

    // ch3 div=0: periodic ticks every cycle, one-shot ticks once
    s_v = 1'b1; s_ch = 2'd3; s_div = 20'd0; s_mode = MODE_PERIODIC;
    cyc();
    s_v = 1'b0; s_en = 4'b1000;
    cyc();
    collect(3, 5);
    chk_ticks("t5_periodic", 5, 1, 2, 3, 4);
    s_en = 4'b0000; s_v = 1'b1; s_ch = 2'd3; s_div = 20'd0; s_mode = MODE_ONESHOT;
    cyc();
    s_v = 1'b0;
    cyc();
    s_en = 4'b1000;
    cyc();
    collect(3, 6);
    chk_ticks("t5_oneshot", 1, 1, 0, 0, 0);
    chk("t5_oneshot_busy", busy[3], 0);
    s_en = '0;
    cyc(); cyc();

    // ch0 reprogrammed to div=4, reset hits during a tick, default div returns
    s_v = 1'b1; s_ch = 2'd0; s_div = 20'd4; s_mode = MODE_PERIODIC;
    cyc();
    s_v = 1'b0; s_en = 4'b0001;
    cyc();
    first = -1;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      cyc();
      if (tick[0]) first = c;
    end
    chk("t6_short_tick", first, 5);
    #2;
    rst_n = 1'b0; s_rst = 1'b0;
    #1;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    cyc();
    s_rst = 1'b1;
    cyc();
    collect(0, 210);
    chk_ticks("t6_default", 2, TB_DIV + 1, 2 * (TB_DIV + 1), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
